// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder.
// Contents:
//   state_e      responder FSM states
//   LOAD_*       funct3 encodings of the load types
//   STORE_*      store lane encoder types
//   misaligned() alignment rule shared by the top level
package memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [1:0] STORE_BYTE = 2'b00;
    localparam logic [1:0] STORE_HALF = 2'b01;
    localparam logic [1:0] STORE_WORD = 2'b10;

    // Only the two low address bits matter for alignment.
    function automatic logic misaligned(input logic [1:0] addr,
                                        input logic       is_store,
                                        input logic [2:0] ltype,
                                        input logic [1:0] stype);
        logic is_half;
        logic is_word;
        if (is_store) begin
            is_half = (stype == STORE_HALF);
            is_word = (stype == STORE_WORD);
        end else begin
            is_half = (ltype == LOAD_LH) || (ltype == LOAD_LHU);
            is_word = (ltype == LOAD_LW);
        end
        return (is_half && addr[0]) || (is_word && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/memory_bank.sv
// DEPTH_WORDS x 32 synchronous word RAM with byte write strobes.
// Ports:
//   clk, reset_n   clock; async active-low reset (read register only)
//   write_strobe   per-byte write enables, lane i = bits [8i+7:8i]
//   write_index    word index for the write
//   write_data     lane-replicated write data
//   read_enable    load read_data from read_index at this edge
//   read_index     word index for the read
//   read_data      registered read word, holds until the next read
module memory_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [3:0]                     write_strobe,
    input  logic [$clog2(DEPTH_WORDS)-1:0] write_index,
    input  logic [31:0]                    write_data,
    input  logic                           read_enable,
    input  logic [$clog2(DEPTH_WORDS)-1:0] read_index,
    output logic [31:0]                    read_data
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] read_data_q;
    logic [31:0] read_data_d;

    // The array itself is never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (write_strobe[i]) begin
                mem_q[write_index][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        if (read_enable) begin
            read_data_d = mem_q[read_index];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: rtl/memory_responder.sv
// Responder end of the core memory handshake, backed by an on-chip word RAM.
// Ports:
//   clk, reset_n               clock; async active-low reset
//   memory_enable              request strobe
//   memory_command             0 = read, 1 = write
//   address                    byte address (high bits alias modulo RAM size)
//   write_data                 unshifted store data
//   load_memory_decoder_type   load funct3 (only used for the misaligned flag)
//   store_memory_encoder_type  store size
//   memory_ready               request can be accepted this cycle
//   memory_valid               one-cycle response pulse
//   read_data                  raw aligned word of the last read
//   misaligned_exception       combinational alignment flag of the inputs
//
// Handshake: a request is accepted at a rising edge where memory_ready=1 and
// memory_enable=1. memory_valid is then high for exactly one cycle, the
// LATENCY-th cycle after the accept edge, and memory_ready stays low from the
// accept edge until the edge that ends the valid cycle. Enable seen while
// ready=0 is ignored. Misaligned stores complete the handshake but write
// nothing; reads always ignore address[1:0].
import memory_responder_pkg::*;

module memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memory_enable,
    input  logic        memory_command,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  load_memory_decoder_type,
    input  logic [1:0]  store_memory_encoder_type,
    output logic        memory_ready,
    output logic        memory_valid,
    output logic [31:0] read_data,
    output logic        misaligned_exception
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W+1:0] addr_q, addr_d;
    logic             cmd_q, cmd_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       stype_q, stype_d;

    logic             idle_ready;
    logic             enter_respond;

    // Request view at the edge entering RESPOND: with LATENCY=1 that edge is
    // the accept edge itself, so the live inputs are used instead of the
    // captured copies.
    logic [IDX_W+1:0] req_addr;
    logic             req_cmd;
    logic [31:0]      req_wdata;
    logic [1:0]       req_stype;
    logic             req_misaligned;

    logic [3:0]       lane_strobe;
    logic [31:0]      lane_data;
    logic             read_enable;

    logic             unused_addr_bits;
    assign unused_addr_bits = ^address[31:IDX_W+2];

    // FSM next state and captures
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        cmd_d         = cmd_q;
        wdata_d       = wdata_q;
        stype_d       = stype_q;
        idle_ready    = 1'b0;
        memory_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (memory_enable) begin
                    addr_d  = address[IDX_W+1:0];
                    cmd_d   = memory_command;
                    wdata_d = write_data;
                    stype_d = store_memory_encoder_type;
                    if (LATENCY == 1) begin
                        state_d = RESPOND;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                memory_valid = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        enter_respond = (state_d == RESPOND) && (state_q != RESPOND);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= '0;
            stype_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            stype_q <= stype_d;
        end
    end

    // Ready is forced low while reset is held, even though the state is IDLE.
    assign memory_ready = idle_ready & reset_n;

    // Lane encoder
    always_comb begin
        if (state_q == IDLE) begin
            req_addr  = address[IDX_W+1:0];
            req_cmd   = memory_command;
            req_wdata = write_data;
            req_stype = store_memory_encoder_type;
        end else begin
            req_addr  = addr_q;
            req_cmd   = cmd_q;
            req_wdata = wdata_q;
            req_stype = stype_q;
        end
        req_misaligned = misaligned(req_addr[1:0], 1'b1, LOAD_LB, req_stype);

        lane_strobe = 4'b0000;
        lane_data   = req_wdata;
        case (req_stype)
            STORE_BYTE: begin
                lane_strobe = 4'b0001 << req_addr[1:0];
                lane_data   = {4{req_wdata[7:0]}};
            end
            STORE_HALF: begin
                lane_strobe = 4'b0011 << req_addr[1:0];
                lane_data   = {2{req_wdata[15:0]}};
            end
            STORE_WORD: begin
                lane_strobe = 4'b1111;
                lane_data   = req_wdata;
            end
            default: begin
                lane_strobe = 4'b0000;
            end
        endcase
        if (!enter_respond || !req_cmd || req_misaligned) begin
            lane_strobe = 4'b0000;
        end
        read_enable = enter_respond && !req_cmd;
    end

    assign misaligned_exception = misaligned(address[1:0], memory_command,
                                             load_memory_decoder_type,
                                             store_memory_encoder_type);

    memory_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_bank (
        .clk          (clk),
        .reset_n      (reset_n),
        .write_strobe (lane_strobe),
        .write_index  (req_addr[IDX_W+1:2]),
        .write_data   (lane_data),
        .read_enable  (read_enable),
        .read_index   (req_addr[IDX_W+1:2]),
        .read_data    (read_data)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances with LATENCY 1, 3 and 4,
// a byte-addressed reference memory, directed steps then random traffic.
module tb_memory_responder;

    logic        clk;
    logic        rst_n [3];
    logic        en    [3];
    logic        cmd   [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [2:0]  lt    [3];
    logic [1:0]  st    [3];
    logic        rdy   [3];
    logic        vld   [3];
    logic        mis   [3];
    logic [31:0] rd    [3];

    int n_checks = 0;
    int n_fail   = 0;
    int lat_of [3] = '{1, 3, 4};

    // reference model: byte memory per instance, key = k*4096 + byte offset
    logic [7:0]  bmem [int];
    logic [31:0] last_rd [3];
    bit          rd_known [3];

    memory_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .INIT_FILE("")) dut0 (
        .clk(clk), .reset_n(rst_n[0]), .memory_enable(en[0]), .memory_command(cmd[0]),
        .address(addr[0]), .write_data(wd[0]), .load_memory_decoder_type(lt[0]),
        .store_memory_encoder_type(st[0]), .memory_ready(rdy[0]), .memory_valid(vld[0]),
        .read_data(rd[0]), .misaligned_exception(mis[0]));

    memory_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .INIT_FILE("")) dut1 (
        .clk(clk), .reset_n(rst_n[1]), .memory_enable(en[1]), .memory_command(cmd[1]),
        .address(addr[1]), .write_data(wd[1]), .load_memory_decoder_type(lt[1]),
        .store_memory_encoder_type(st[1]), .memory_ready(rdy[1]), .memory_valid(vld[1]),
        .read_data(rd[1]), .misaligned_exception(mis[1]));

    memory_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .INIT_FILE("")) dut2 (
        .clk(clk), .reset_n(rst_n[2]), .memory_enable(en[2]), .memory_command(cmd[2]),
        .address(addr[2]), .write_data(wd[2]), .load_memory_decoder_type(lt[2]),
        .store_memory_encoder_type(st[2]), .memory_ready(rdy[2]), .memory_valid(vld[2]),
        .read_data(rd[2]), .misaligned_exception(mis[2]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input bit c, input logic [2:0] l, input logic [1:0] s);
        if (c) begin
            if (s == 2'd0) return 1;
            if (s == 2'd1) return 2;
            if (s == 2'd2) return 4;
            return 0;
        end
        if (l[1:0] == 2'd0) return 1;
        if (l[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_mis(input bit c, input logic [31:0] a,
                                     input logic [2:0] l, input logic [1:0] s);
        int sz;
        sz = size_of(c, l, s);
        return (sz > 1) && ((int'(a[1:0]) % sz) != 0);
    endfunction

    function automatic int key_of(input int k, input logic [31:0] a);
        return k * 4096 + int'(a % 32'd4096);
    endfunction

    task automatic model_store(input int k, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s);
        int sz;
        sz = size_of(1'b1, 3'd0, s);
        if (sz == 0 || model_mis(1'b1, a, 3'd0, s)) return;
        for (int b = 0; b < sz; b++) bmem[key_of(k, a) + b] = d[8*b +: 8];
    endtask

    task automatic model_load(input int k, input logic [31:0] a,
                              output bit known, output logic [31:0] w);
        int base;
        base  = key_of(k, a) - int'(a[1:0]);
        known = 1'b1;
        w     = '0;
        for (int b = 0; b < 4; b++) begin
            if (bmem.exists(base + b)) w[8*b +: 8] = bmem[base + b];
            else known = 1'b0;
        end
    endtask

    // driver: one complete transaction on instance k, checked cycle by cycle
    task automatic do_txn(input int k, input bit c, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] l, input logic [1:0] s);
        bit          known;
        logic [31:0] w;
        int          lat;
        lat = lat_of[k];
        for (int t = 0; t < 50 && rdy[k] !== 1'b1; t++) @(negedge clk);
        check("ready_before_request", 32'(rdy[k]), 32'd1);
        en[k] = 1'b1; cmd[k] = c; addr[k] = a; wd[k] = d; lt[k] = l; st[k] = s;
        #1;
        check("misaligned_flag", 32'(mis[k]), 32'(model_mis(c, a, l, s)));
        @(posedge clk);
        @(negedge clk);
        en[k] = 1'b0;
        for (int j = 1; j <= lat; j++) begin
            if (j > 1) @(negedge clk);
            check("valid_in_window", 32'(vld[k]), 32'(j == lat));
            check("ready_low_busy", 32'(rdy[k]), 32'd0);
            if (j == lat) begin
                if (!c) begin
                    model_load(k, a, known, w);
                    if (known) check("read_data", rd[k], w);
                    last_rd[k]  = w;
                    rd_known[k] = known;
                end else if (rd_known[k]) begin
                    check("read_data_held_on_write", rd[k], last_rd[k]);
                end
            end
        end
        if (c) model_store(k, a, d, s);
        @(negedge clk);
        check("valid_after_response", 32'(vld[k]), 32'd0);
        check("ready_after_response", 32'(rdy[k]), 32'd1);
    endtask

    initial begin
        bit          known;
        logic [31:0] w;
        logic [2:0]  ltypes [5];
        ltypes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; en[k] = 1'b0; cmd[k] = 1'b0; addr[k] = '0;
            wd[k] = '0; lt[k] = 3'd2; st[k] = 2'd2;
            last_rd[k] = '0; rd_known[k] = 1'b1;
        end

        // reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", 32'(rdy[k]), 32'd0);
            check("reset_valid", 32'(vld[k]), 32'd0);
            check("reset_read_data", rd[k], 32'd0);
        end
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check("ready_after_release", 32'(rdy[k]), 32'd1);
        @(negedge clk);

        // word round trip and byte lanes (LATENCY=1)
        do_txn(0, 1'b1, 32'h100, 32'h11223344, 3'd2, 2'd2);
        do_txn(0, 1'b0, 32'h100, 32'h0, 3'd2, 2'd2);
        check("lw_after_sw", rd[0], 32'h11223344);
        do_txn(0, 1'b1, 32'h103, 32'h000000AB, 3'd2, 2'd0);
        do_txn(0, 1'b0, 32'h100, 32'h0, 3'd2, 2'd2);
        check("lw_after_sb", rd[0], 32'hAB223344);
        do_txn(0, 1'b1, 32'h102, 32'h0000BEEF, 3'd2, 2'd1);
        do_txn(0, 1'b0, 32'h100, 32'h0, 3'd2, 2'd2);
        check("lw_after_sh", rd[0], 32'hBEEF3344);

        // misaligned: flag with enable low, misaligned store writes nothing
        en[0] = 1'b0; cmd[0] = 1'b0; addr[0] = 32'h101; lt[0] = 3'd1;
        #1;
        check("lh_0x101_flag", 32'(mis[0]), 32'd1);
        do_txn(0, 1'b1, 32'h102, 32'h99999999, 3'd2, 2'd2);
        do_txn(0, 1'b0, 32'h100, 32'h0, 3'd2, 2'd2);
        check("ram_kept_after_misaligned_sw", rd[0], 32'hBEEF3344);
        do_txn(0, 1'b0, 32'h104, 32'h0, 3'd2, 2'd2);
        addr[0] = 32'h104; cmd[0] = 1'b0; lt[0] = 3'd2;
        #1;
        check("lw_0x104_flag", 32'(mis[0]), 32'd0);

        // latency 3 round trip
        do_txn(1, 1'b1, 32'h40, 32'hCAFEF00D, 3'd2, 2'd2);
        do_txn(1, 1'b0, 32'h40, 32'h0, 3'd2, 2'd2);
        check("lat3_round_trip", rd[1], 32'hCAFEF00D);

        // held enable on LATENCY=1: accept, respond, accept, ...
        @(negedge clk);
        en[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 32'h100; lt[0] = 3'd2;
        model_load(0, 32'h100, known, w);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("held_valid", 32'(vld[0]), 32'(i % 2));
            check("held_ready", 32'(rdy[0]), 32'((i + 1) % 2));
            if (i % 2 == 1) check("held_read_data", rd[0], w);
        end
        en[0] = 1'b0;
        last_rd[0] = w; rd_known[0] = known;

        // reset in the middle of a pending write (LATENCY=4)
        do_txn(2, 1'b1, 32'h200, 32'h55667788, 3'd2, 2'd2);
        en[2] = 1'b1; cmd[2] = 1'b1; addr[2] = 32'h200; wd[2] = 32'hDEADBEEF; st[2] = 2'd2;
        @(posedge clk);
        @(negedge clk);
        en[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        check("midreset_ready", 32'(rdy[2]), 32'd0);
        check("midreset_valid", 32'(vld[2]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreset_valid_held", 32'(vld[2]), 32'd0);
            check("midreset_ready_held", 32'(rdy[2]), 32'd0);
        end
        rst_n[2] = 1'b1;
        #1;
        check("ready_after_midreset", 32'(rdy[2]), 32'd1);
        last_rd[2] = '0; rd_known[2] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_valid_after_midreset", 32'(vld[2]), 32'd0);
        end
        do_txn(2, 1'b0, 32'h200, 32'h0, 3'd2, 2'd2);
        check("pending_write_discarded", rd[2], 32'h55667788);

        // random traffic: fill a 16-word window, then mixed accesses with aliasing
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                do_txn(k, 1'b1, 32'(i * 4), $urandom, 3'd2, 2'd2);
        for (int i = 0; i < 60; i++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, 2);
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            do_txn(k, 1'($urandom_range(0, 1)), a, $urandom,
                   ltypes[$urandom_range(0, 4)], 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
